hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV32I core; it sequences the execute-stage datapath.
- Keeps its own shadow of in-flight register destinations for the E, M and W stages.
- Drives the ForwardAE/ForwardBE operand-select codes into the execute stage.
- Detects load-use hazards and taken branches, and issues stall/flush to the fetch, decode and execute pipeline registers.
- Counts stall and flush events for performance monitoring.

---
 rtl/core_pkg.sv | 47 ++++
 rtl/sat_counter.sv | 36 +++
 rtl/hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared definitions for the 5-stage RV32I core. Holds the
//               execute-stage operand-forwarding encodings, the register
//               index width, the hazard-unit stage shadow records and a
//               small helper used by the forwarding logic.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    // Register-file index width (32 architectural registers)
    localparam int REG_AW = 5;

    // Operand-select codes shared with the execute-stage operand muxes
    localparam logic [1:0] FWD_RF  = 2'b00;   // register-file read data
    localparam logic [1:0] FWD_WB  = 2'b01;   // ResultW (writeback)
    localparam logic [1:0] FWD_MEM = 2'b10;   // ALUResultM (memory stage)

    // Shadow of the instruction currently in the execute stage
    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              load;
        logic              valid;
    } ex_rec_t;

    // Shadow of the instructions in the memory and writeback stages
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              load;
        logic              valid;
    } mw_rec_t;

    // A stage can supply a forwarded value only if it really writes a
    // register other than x0 (x0 is hardwired to zero).
    function automatic logic fwd_eligible(input logic              valid,
                                          input logic              regwrite,
                                          input logic [REG_AW-1:0] rd);
        return valid & regwrite & (rd != '0);
    endfunction

endpackage : core_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Event counter that increments by one per cycle while i_inc
//               is high and sticks at all-ones instead of wrapping.
// Ports       : clk     - clock, rising edge
//               rst_n   - asynchronous active-low reset (count -> 0)
//               i_inc   - count this cycle
//               o_count - current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] c_max = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller for the 5-stage RV32I core.
//               Keeps a shadow of the destination/source indices of the
//               instructions in E, M and W, selects execute-stage operand
//               forwarding, detects load-use hazards and taken branches,
//               and drives stall/flush to the IF/ID and ID/EX registers.
//               Stall cycles and branch flushes are counted (saturating).
// Ports       : clk, rst_n            - clock / async active-low reset
//               Rs1D, Rs2D, RdD       - decode-stage register indices
//               RegWriteD, LoadD      - decode instruction attributes
//               ValidD                - decode slot holds a real instruction
//               PCSrcE                - taken branch/jump resolved in E
//               ForwardAE, ForwardBE  - execute operand selects
//               StallF, StallD        - hold PC / IF-ID register
//               FlushD, FlushE        - clear IF-ID / ID-EX register
//               StallCnt, FlushCnt    - saturating event counters
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic              RegWriteD,
    input  logic              LoadD,
    input  logic              ValidD,
    input  logic              PCSrcE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt
);

    import core_pkg::*;

    // ------------------------------------------------------------------
    // Stage shadow records
    // ------------------------------------------------------------------
    ex_rec_t r_e;
    mw_rec_t r_m;
    mw_rec_t r_w;

    logic w_lw_stall;
    logic w_stall;
    logic w_flush_d;
    logic w_flush_e;
    logic w_m_fwd;
    logic w_w_fwd;

    // The load flag is carried into W only so the record layout is uniform;
    // nothing downstream of M needs it.
    logic w_unused_wload;
    assign w_unused_wload = r_w.load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e <= '0;
            r_m <= '0;
            r_w <= '0;
        end else begin
            r_w <= r_m;
            r_m <= '{rd: r_e.rd, regwrite: r_e.regwrite,
                     load: r_e.load, valid: r_e.valid};
            // E always advances; a stall is realised as a bubble in E
            // while the decode instruction is held upstream.
            if (w_flush_e) begin
                r_e <= '0;
            end else begin
                r_e <= '{rs1: Rs1D, rs2: Rs2D, rd: RdD, regwrite: RegWriteD,
                         load: LoadD, valid: ValidD};
            end
        end
    end

    // ------------------------------------------------------------------
    // Forwarding. A load in M has no data yet, so it never sources a
    // forward; the load-use stall keeps a dependent out of E that cycle.
    // ------------------------------------------------------------------
    assign w_m_fwd = fwd_eligible(r_m.valid, r_m.regwrite, r_m.rd) & ~r_m.load;
    assign w_w_fwd = fwd_eligible(r_w.valid, r_w.regwrite, r_w.rd);

    always_comb begin
        ForwardAE = FWD_RF;
        if (w_m_fwd && (r_m.rd == r_e.rs1)) begin
            ForwardAE = FWD_MEM;
        end else if (w_w_fwd && (r_w.rd == r_e.rs1)) begin
            ForwardAE = FWD_WB;
        end

        ForwardBE = FWD_RF;
        if (w_m_fwd && (r_m.rd == r_e.rs2)) begin
            ForwardBE = FWD_MEM;
        end else if (w_w_fwd && (r_w.rd == r_e.rs2)) begin
            ForwardBE = FWD_WB;
        end
    end

    // ------------------------------------------------------------------
    // Stall / flush. Gated by rst_n so reset silences them immediately,
    // including the PCSrcE-driven flushes which come straight from an input.
    // ------------------------------------------------------------------
    assign w_lw_stall = r_e.valid & r_e.load & (r_e.rd != '0) & ValidD &
                        ((r_e.rd == Rs1D) | (r_e.rd == Rs2D));

    // A taken branch discards the stalled decode instruction, so it wins.
    assign w_stall   = rst_n & w_lw_stall & ~PCSrcE;
    assign w_flush_d = rst_n & PCSrcE;
    assign w_flush_e = rst_n & (w_lw_stall | PCSrcE);

    assign StallF = w_stall;
    assign StallD = w_stall;
    assign FlushD = w_flush_d;
    assign FlushE = w_flush_e;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_stall),
        .o_count (StallCnt)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_flush_d),
        .o_count (FlushCnt)
    );

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl. A narrow
//               3-bit counter instance lets saturation be reached quickly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 3;

    logic              clk;
    logic              rst_n;
    logic [REG_AW-1:0] Rs1D, Rs2D, RdD;
    logic              RegWriteD, LoadD, ValidD, PCSrcE;
    logic [1:0]        ForwardAE, ForwardBE;
    logic              StallF, StallD, FlushD, FlushE;
    logic [CNT_W-1:0]  StallCnt, FlushCnt;

    int vectors;
    int miscompares;

    hazard_ctrl #(
        .REG_AW (REG_AW),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Rs1D      (Rs1D),
        .Rs2D      (Rs2D),
        .RdD       (RdD),
        .RegWriteD (RegWriteD),
        .LoadD     (LoadD),
        .ValidD    (ValidD),
        .PCSrcE    (PCSrcE),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .FlushE    (FlushE),
        .StallCnt  (StallCnt),
        .FlushCnt  (FlushCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a decode-stage instruction, then let combinational logic settle
    task automatic dec(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic ld, input logic v);
        Rs1D = rs1; Rs2D = rs2; RdD = rd; RegWriteD = rw; LoadD = ld; ValidD = v;
        #1;
    endtask

    task automatic nop();
        dec(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // stall/flush outputs packed as {StallF, StallD, FlushD, FlushE}
    function automatic logic [3:0] sf();
        return {StallF, StallD, FlushD, FlushE};
    endfunction

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; PCSrcE = 1'b0;
        nop();

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_sf",     sf(),      4'b0000);
        chk("rst_fa",     ForwardAE, 2'b00);
        chk("rst_stcnt",  StallCnt,  3'd0);
        chk("rst_flcnt",  FlushCnt,  3'd0);
        rst_n = 1'b1;
        tick();

        // ---------------- add x5 ; sub x6,x5,x3 ----------------
        dec(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1);
        chk("add_nostall", sf(), 4'b0000);
        tick();
        dec(5'd5, 5'd3, 5'd6, 1'b1, 1'b0, 1'b1);
        chk("sub_nostall", sf(), 4'b0000);
        tick();
        nop();
        chk("sub_fa_mem", ForwardAE, 2'b10);
        chk("sub_fb_rf",  ForwardBE, 2'b00);
        tick(); tick(); tick();

        // ---------------- add x5 ; nop ; or x7,x4,x5 ----------------
        dec(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1); tick();
        nop();                                   tick();
        dec(5'd4, 5'd5, 5'd7, 1'b1, 1'b0, 1'b1); tick();
        nop();
        chk("or_fb_wb", ForwardBE, 2'b01);
        chk("or_fa_rf", ForwardAE, 2'b00);
        tick(); tick(); tick();

        // ---------------- add x5 ; add x5 ; or : M wins over W ----------------
        dec(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1); tick();
        dec(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1); tick();
        dec(5'd4, 5'd5, 5'd7, 1'b1, 1'b0, 1'b1); tick();
        nop();
        chk("or_fb_prio", ForwardBE, 2'b10);
        tick(); tick(); tick();

        // ---------------- lw x5 ; add x6,x5,x2 ----------------
        dec(5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1); tick();
        dec(5'd5, 5'd2, 5'd6, 1'b1, 1'b0, 1'b1);
        chk("lu_stall", sf(), 4'b1101);
        tick();                      // E bubble, decode held
        chk("lu_one_cycle", sf(), 4'b0000);
        tick();                      // dependent now in E, load in W
        nop();
        chk("lu_fa_wb",  ForwardAE, 2'b01);
        chk("lu_stcnt",  StallCnt,  3'd1);
        tick(); tick(); tick();

        // ------- ValidD=0 never stalls; load in M is not forwarded -------
        dec(5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1); tick();
        dec(5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
        chk("invalid_nostall", sf(), 4'b0000);
        tick();
        nop();
        chk("mload_nofwd", ForwardAE, 2'b00);
        tick(); tick(); tick();

        // ---------------- x0 never forwarded / stalled ----------------
        dec(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1); tick();
        dec(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1); tick();
        nop();
        chk("x0_fa", ForwardAE, 2'b00);
        chk("x0_fb", ForwardBE, 2'b00);
        tick(); tick(); tick();
        dec(5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1); tick();
        dec(5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1);
        chk("x0_lw_nostall", sf(), 4'b0000);
        tick(); nop(); tick(); tick(); tick();

        // ---------------- load-use + taken branch ----------------
        dec(5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1); tick();
        dec(5'd5, 5'd2, 5'd6, 1'b1, 1'b0, 1'b1);
        PCSrcE = 1'b1; #1;
        chk("br_wins", sf(), 4'b0011);
        tick();
        PCSrcE = 1'b0; nop();
        chk("br_flcnt", FlushCnt, 3'd1);
        chk("br_stcnt", StallCnt, 3'd1);
        tick(); tick(); tick();

        // ---------------- reset during a load-use stall ----------------
        dec(5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1); tick();
        dec(5'd5, 5'd2, 5'd6, 1'b1, 1'b0, 1'b1);
        chk("pre_rst_stall", sf(), 4'b1101);
        rst_n = 1'b0; PCSrcE = 1'b1; #1;
        chk("inrst_sf",    sf(),     4'b0000);
        chk("inrst_stcnt", StallCnt, 3'd0);
        chk("inrst_flcnt", FlushCnt, 3'd0);
        tick(); tick();
        PCSrcE = 1'b0; rst_n = 1'b1; #1;
        chk("postrst_sf", sf(),      4'b0000);
        chk("postrst_fa", ForwardAE, 2'b00);
        tick();
        chk("postrst_stcnt", StallCnt, 3'd0);

        // ---------------- saturation (3-bit counter, max 7) ----------------
        for (int i = 0; i < 6; i++) begin
            dec(5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1); tick();
            dec(5'd5, 5'd2, 5'd6, 1'b1, 1'b0, 1'b1); tick();
        end
        chk("sat_pre", StallCnt, 3'd6);
        for (int i = 0; i < 3; i++) begin
            dec(5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1); tick();
            dec(5'd5, 5'd2, 5'd6, 1'b1, 1'b0, 1'b1); tick();
        end
        chk("sat_hold", StallCnt, 3'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_hazard_ctrl
`default_nettype wire
